rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The module SHALL have parameter REFRESH_INTERVAL, default 780, the number of clk cycles between refresh requests while loading.
REQ-002 The module SHALL have port clk  input  1  main logic clock, all state on its rising edge.
REQ-003 The module SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 The module SHALL have ports in_valid  input  1 and in_data  input  8, carrying iNES file bytes in file order.
REQ-005 The module SHALL have port in_ready  output  1; a byte transfers on a cycle with in_valid && in_ready.
REQ-006 The module SHALL have ports mem_write  output  1, mem_refresh  output  1, mem_addr  output  22, mem_din  output  8; these are single-cycle requests to the memory controller.
REQ-007 The module SHALL have port mem_busy  input  1, the memory controller busy flag.
REQ-008 The module SHALL have ports mapper  output  8, prg_units  output  8, chr_units  output  8, done  output  1, error  output  1.

Function
REQ-009 The state machine SHALL have states HEADER, TRAINER, PRG, CHR, DONE and ERROR.
REQ-010 In HEADER, in_ready SHALL be 1 and 16 bytes SHALL be consumed; bytes 0-3 SHALL be checked against 4E 45 53 1A.
REQ-011 Byte 4 SHALL latch prg_units, byte 5 chr_units; mapper SHALL equal {byte7[7:4], byte6[7:4]}.
REQ-012 After byte 15, the next state SHALL be ERROR on magic mismatch, prg_units==0, prg_units>128 or chr_units>192; otherwise TRAINER if byte6[2]==1, else PRG.
REQ-013 TRAINER SHALL consume and discard 512 bytes with in_ready=1, then go to PRG.
REQ-014 PRG SHALL write prg_units*16384 bytes to mem_addr = 0x000000 + index; CHR SHALL write chr_units*8192 bytes to 0x200000 + index. Index is 21 bits and resets to 0 on entering each state.
REQ-015 In PRG/CHR, an accepted byte SHALL set an internal pending flag; in_ready = !pending.
REQ-016 When pending && !mem_busy && !mem_write && !mem_refresh, the next cycle SHALL have mem_write=1 for exactly one cycle with mem_addr/mem_din valid, and pending SHALL clear in that cycle.
REQ-017 mem_write and mem_refresh SHALL never be high in the same cycle, and neither SHALL be high on two consecutive cycles.
REQ-018 After the final PRG write, the state SHALL go to CHR, or to DONE if chr_units==0; after the final CHR write it SHALL go to DONE.
REQ-019 In DONE, done=1; in ERROR, error=1. In both states, in_ready=0 and no memory requests SHALL be issued until reset.
REQ-020 mem_din and mem_addr SHALL hold their last value when no request is active.

Reset
REQ-021 On resetn=0, state SHALL be HEADER, with pending, mem_write, mem_refresh, done and error = 0; mem_addr, mem_din, mapper, prg_units, chr_units, index and the refresh counter = 0.
REQ-022 Reset asserted mid-load SHALL abort immediately; a partially written image SHALL be left as is.

Configuration
REQ-023 With macro ROM_LOADER_REFRESH_EN defined, a counter SHALL count clk cycles in HEADER/TRAINER/PRG/CHR; on reaching REFRESH_INTERVAL-1 it SHALL set refresh_due.
REQ-024 With ROM_LOADER_REFRESH_EN defined, refresh_due SHALL take priority over a pending write: when !mem_busy && !mem_write && !mem_refresh, the next cycle SHALL have mem_refresh=1, and the counter and refresh_due SHALL clear.
REQ-025 Without ROM_LOADER_REFRESH_EN, mem_refresh SHALL be constant 0 and no counter SHALL be built.

Verification
REQ-026 Header 4E 45 53 1A 01 01 10 00 + 8 zeros, then 16384+8192 bytes, with mem_busy high for 3 cycles after each write -> 24576 writes; first at 0x000000, first CHR at 0x200000, last at 0x201FFF; mapper=0x01; done=1.
REQ-027 Magic byte 3 = 0x1B -> error=1 after byte 15, in_ready=0, no mem_write ever.
REQ-028 byte6[2]=1 -> 512 bytes consumed with no writes; the 529th byte is written to 0x000000.
REQ-029 chr_units=0 -> DONE directly after the last PRG write at 0x003FFF; no address >= 0x200000 is issued.
REQ-030 REFRESH_EN with REFRESH_INTERVAL=16, write pending at the moment refresh_due is set -> mem_refresh precedes that mem_write; never both in one cycle.
REQ-031 resetn pulsed low after 100 PRG writes -> all outputs return to reset values; the reload restarts at HEADER and the first write goes to 0x000000.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: streams an iNES image (16-byte header, optional 512-byte trainer,
// PRG and CHR payloads) from a byte-wide valid/ready input into external memory.
// PRG lands at 0x000000 and CHR at 0x200000. Each payload byte is buffered, then
// issued as a single-cycle write once the memory controller is idle.
// Build option: define ROM_LOADER_REFRESH_EN to add periodic single-cycle refresh
// requests every REFRESH_INTERVAL cycles while loading. Without it, mem_refresh is tied low.
module rom_loader #(
    parameter int unsigned REFRESH_INTERVAL = 780
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_write,
    output logic        mem_refresh,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic        mem_busy,
    output logic [7:0]  mapper,
    output logic [7:0]  prg_units,
    output logic [7:0]  chr_units,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StHeader,
        StTrainer,
        StPrg,
        StChr,
        StDone,
        StError
    } state_e;

    state_e      state;
    logic [3:0]  hdr_idx;
    logic        magic_bad;
    logic        has_trainer;
    logic [20:0] index;
    logic        pending;
    logic [7:0]  data_buf;

    logic        accept;
    logic        loading;
    logic        req_free;
    logic        refresh_go;
    logic        write_go;
    logic        last_write;
    logic [21:0] section_len;
    logic [7:0]  magic_byte;

    // Input readiness: header/trainer always take bytes, payload phases take one per write
    always_comb begin
        unique case (state)
            StHeader, StTrainer: in_ready = 1'b1;
            StPrg, StChr:        in_ready = !pending;
            default:             in_ready = 1'b0;
        endcase
    end

    // Expected magic byte for header positions 0-3
    always_comb begin
        unique case (hdr_idx[1:0])
            2'd0:    magic_byte = 8'h4E;
            2'd1:    magic_byte = 8'h45;
            2'd2:    magic_byte = 8'h53;
            default: magic_byte = 8'h1A;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign loading  = (state == StHeader) || (state == StTrainer) ||
                      (state == StPrg) || (state == StChr);
    // A new request may only launch when the controller is idle and no request was just issued
    assign req_free = !mem_busy && !mem_write && !mem_refresh;

    // PRG units are 16 KiB, CHR units 8 KiB; 22 bits holds 128 * 16 KiB
    assign section_len = (state == StChr) ? {1'b0, chr_units, 13'b0} : {prg_units, 14'b0};
    assign last_write  = ({1'b0, index} == (section_len - 22'd1));

    assign write_go = ((state == StPrg) || (state == StChr)) && pending && req_free &&
                      !refresh_go;

`ifdef ROM_LOADER_REFRESH_EN
    localparam int unsigned CntW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    logic [CntW-1:0] refresh_cnt;
    logic            refresh_due;

    // A due refresh wins over a buffered write
    assign refresh_go = refresh_due && req_free && loading;

    // Refresh timer: counts loading cycles, raises refresh_due, clears when the refresh issues
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt <= '0;
            refresh_due <= 1'b0;
            mem_refresh <= 1'b0;
        end else begin
            mem_refresh <= 1'b0;
            if (refresh_go) begin
                mem_refresh <= 1'b1;
                refresh_cnt <= '0;
                refresh_due <= 1'b0;
            end else if (loading && !refresh_due) begin
                if (refresh_cnt == CntW'(REFRESH_INTERVAL - 1)) begin
                    refresh_due <= 1'b1;
                end else begin
                    refresh_cnt <= refresh_cnt + 1'b1;
                end
            end
        end
    end
`else
    // Keeps the interval parameter referenced when refresh is compiled out
    logic unused_interval;
    assign unused_interval = ^REFRESH_INTERVAL;
    assign mem_refresh     = 1'b0;
    assign refresh_go      = 1'b0;
`endif

    // Loader FSM: header parse, trainer skip, PRG/CHR write-out, terminal states
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= StHeader;
            hdr_idx     <= '0;
            magic_bad   <= 1'b0;
            has_trainer <= 1'b0;
            index       <= '0;
            pending     <= 1'b0;
            data_buf    <= '0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mapper      <= '0;
            prg_units   <= '0;
            chr_units   <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            unique case (state)
                StHeader: begin
                    if (accept) begin
                        hdr_idx <= hdr_idx + 4'd1;
                        unique case (hdr_idx)
                            4'd0, 4'd1, 4'd2, 4'd3: begin
                                if (in_data != magic_byte) magic_bad <= 1'b1;
                            end
                            4'd4: prg_units <= in_data;
                            4'd5: chr_units <= in_data;
                            4'd6: begin
                                mapper[3:0] <= in_data[7:4];
                                has_trainer <= in_data[2];
                            end
                            4'd7: mapper[7:4] <= in_data[7:4];
                            4'd15: begin
                                index <= '0;
                                if (magic_bad || (prg_units == 8'd0) ||
                                    (prg_units > 8'd128) || (chr_units > 8'd192)) begin
                                    state <= StError;
                                    error <= 1'b1;
                                end else if (has_trainer) begin
                                    state <= StTrainer;
                                end else begin
                                    state <= StPrg;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StTrainer: begin
                    if (accept) begin
                        if (index == 21'd511) begin
                            index <= '0;
                            state <= StPrg;
                        end else begin
                            index <= index + 21'd1;
                        end
                    end
                end
                StPrg, StChr: begin
                    if (write_go) begin
                        mem_write <= 1'b1;
                        mem_addr  <= {(state == StChr), index};
                        mem_din   <= data_buf;
                        pending   <= 1'b0;
                        if (last_write) begin
                            index <= '0;
                            if ((state == StChr) || (chr_units == 8'd0)) begin
                                state <= StDone;
                                done  <= 1'b1;
                            end else begin
                                state <= StChr;
                            end
                        end else begin
                            index <= index + 21'd1;
                        end
                    end else if (accept) begin
                        pending  <= 1'b1;
                        data_buf <= in_data;
                    end
                end
                default: ; // StDone / StError hold until reset
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed bench for rom_loader. A negedge monitor models the
// memory controller busy flag and tracks every request for address/data ordering
// and protocol checks; the stimulus process streams headers and payloads.
module tb_rom_loader;

    localparam int unsigned Interval   = 16;
    localparam int          StallLimit = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_write;
    logic        mem_refresh;
    logic [21:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_busy = 1'b0;
    logic [7:0]  mapper;
    logic [7:0]  prg_units;
    logic [7:0]  chr_units;
    logic        done;
    logic        error;

    rom_loader #(
        .REFRESH_INTERVAL(Interval)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_write  (mem_write),
        .mem_refresh(mem_refresh),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_busy   (mem_busy),
        .mapper     (mapper),
        .prg_units  (prg_units),
        .chr_units  (chr_units),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor-owned counters
    int          wr_cnt = 0;
    int          ref_cnt = 0;
    int          seq_err = 0;
    int          proto_err = 0;
    int          hi_cnt = 0;
    int          ref_pend_cnt = 0;
    int          busy_cnt = 0;
    bit          prev_req = 1'b0;
    logic [21:0] first_addr = '0;
    logic [21:0] chr_first_addr = '0;
    logic [21:0] last_addr = '0;
    logic [7:0]  first_din = '0;

    // Stimulus-owned settings
    int wr_base = 0;
    int prg_bytes = 0;
    int tot_bytes = 0;
    bit busy_on = 1'b0;
    bit payload = 1'b0;
    bit aborted = 1'b0;
    int acc_cnt = 0;

    // Header sanity table: magic byte 3, prg units, chr units, error expected
    logic [7:0] hv_m3  [5] = '{8'h1B, 8'h1A, 8'h1A, 8'h1A, 8'h1A};
    logic [7:0] hv_prg [5] = '{8'd1, 8'd0, 8'd129, 8'd1, 8'd128};
    logic [7:0] hv_chr [5] = '{8'd1, 8'd1, 8'd0, 8'd193, 8'd192};
    bit         hv_err [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'((k ^ (k >> 8)) ^ 32'h5A);
    endfunction

    // Busy is applied around the interesting stretches only, to bound the run length
    function automatic bit busy_win(input int k, input int pb, input int tb);
        return (k < 32) || ((k >= pb - 16) && (k < pb + 16)) || (k >= tb - 16);
    endfunction

    // Payload handshakes, counted at the transfer edge
    always @(posedge clk) begin
        if (payload && in_valid && in_ready) acc_cnt++;
    end

    // Memory-side monitor and busy model
    always @(negedge clk) begin : monitor
        int          k;
        logic [21:0] ea;
        k = wr_cnt - wr_base;
        if (mem_write && mem_refresh) proto_err++;
        if ((mem_write || mem_refresh) && (prev_req || mem_busy)) proto_err++;
        if (mem_refresh) begin
            ref_cnt++;
            if (acc_cnt > wr_cnt) ref_pend_cnt++;
        end
        if (mem_write) begin
            ea = (k < prg_bytes) ? 22'(k) : 22'h200000 + 22'(k - prg_bytes);
            if ((mem_addr !== ea) || (mem_din !== pat(k))) seq_err++;
            if (k == 0) begin
                first_addr = mem_addr;
                first_din  = mem_din;
            end
            if (k == prg_bytes) chr_first_addr = mem_addr;
            if (mem_addr >= 22'h200000) hi_cnt++;
            last_addr = mem_addr;
            wr_cnt++;
        end
        prev_req = mem_write || mem_refresh;
        if (busy_cnt > 0) busy_cnt--;
        if (mem_write && busy_on && busy_win(k, prg_bytes, tot_bytes)) busy_cnt = 3;
        mem_busy = (busy_cnt != 0);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (aborted) return;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready) begin
            if (n == StallLimit) begin
                aborted  = 1'b1;
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] m3, input logic [7:0] prg,
                               input logic [7:0] chr, input logic [7:0] f6,
                               input logic [7:0] f7);
        logic [7:0] h [16];
        foreach (h[i]) h[i] = 8'h00;
        h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = m3;
        h[4] = prg;   h[5] = chr;   h[6] = f6;    h[7] = f7;
        for (int i = 0; i < 16; i++) send_byte(h[i]);
    endtask

    task automatic send_payload(input int n);
        payload = 1'b1;
        for (int k = 0; k < n; k++) send_byte(pat(k));
        payload = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(negedge clk);
        resetn  = 1'b1;
        aborted = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        #1;
        check(tag, done, 1);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (((wr_cnt - wr_base) < target) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        #1;
    endtask

    int seq_base;
    int ref_base;
    int rp_base;
    int hi_base;

    initial begin
        // Reset state
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_refresh", mem_refresh, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_mapper", mapper, 0);
        check("rst_units", {prg_units, chr_units}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;

        // Full image: 1 PRG unit, 1 CHR unit, mapper 1
        wr_base = wr_cnt; seq_base = seq_err; ref_base = ref_cnt; rp_base = ref_pend_cnt;
        prg_bytes = 16384; tot_bytes = 24576; busy_on = 1'b1;
        send_header(8'h1A, 8'h01, 8'h01, 8'h10, 8'h00);
        #1;
        check("main_mapper", mapper, 8'h01);
        check("main_prg_units", prg_units, 8'd1);
        check("main_chr_units", chr_units, 8'd1);
        send_payload(24576);
        wait_done("main_done", 64);
        check("main_stall", aborted, 0);
        check("main_writes", wr_cnt - wr_base, 24576);
        check("main_first_addr", first_addr, 22'h000000);
        check("main_first_din", first_din, 8'h5A);
        check("main_chr_first", chr_first_addr, 22'h200000);
        check("main_last_addr", last_addr, 22'h201FFF);
        check("main_sequence", seq_err - seq_base, 0);
        check("main_error", error, 0);
        check("main_ready_done", in_ready, 0);
`ifdef ROM_LOADER_REFRESH_EN
        check("main_refresh_seen", (ref_cnt - ref_base) > 0, 1);
        check("refresh_before_write", (ref_pend_cnt - rp_base) > 0, 1);
`else
        check("refresh_idle", ref_cnt, 0);
`endif

        // Header sanity table
        busy_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            wr_base = wr_cnt;
            send_header(hv_m3[i], hv_prg[i], hv_chr[i], 8'h00, 8'h00);
            #1;
            check($sformatf("hdr%0d_error", i), error, 32'(hv_err[i]));
            check($sformatf("hdr%0d_ready", i), in_ready, 32'(!hv_err[i]));
            if (hv_err[i]) begin
                in_valid = 1'b1;
                in_data  = 8'h55;
                repeat (20) @(negedge clk);
                in_valid = 1'b0;
                #1;
                check($sformatf("hdr%0d_done", i), done, 0);
            end
            check($sformatf("hdr%0d_writes", i), wr_cnt - wr_base, 0);
        end

        // Trainer skip and CHR-less image
        do_reset();
        wr_base = wr_cnt; seq_base = seq_err; hi_base = hi_cnt;
        prg_bytes = 16384; tot_bytes = 16384; busy_on = 1'b1;
        send_header(8'h1A, 8'h01, 8'h00, 8'h04, 8'h00);
        for (int i = 0; i < 512; i++) send_byte(8'hEE);
        #1;
        check("trn_writes", wr_cnt - wr_base, 0);
        check("trn_ready", in_ready, 1);
        send_payload(16384);
        wait_done("trn_done", 64);
        check("trn_stall", aborted, 0);
        check("trn_writes_total", wr_cnt - wr_base, 16384);
        check("trn_first_addr", first_addr, 22'h000000);
        check("trn_first_din", first_din, 8'h5A);
        check("trn_last_addr", last_addr, 22'h003FFF);
        check("trn_no_chr_addr", hi_cnt - hi_base, 0);
        check("trn_sequence", seq_err - seq_base, 0);

        // Reset mid-load, then reload
        do_reset();
        wr_base = wr_cnt; seq_base = seq_err;
        prg_bytes = 32768; tot_bytes = 32768; busy_on = 1'b0;
        send_header(8'h1A, 8'h02, 8'h00, 8'h30, 8'h40);
        #1;
        check("mid_mapper", mapper, 8'h43);
        send_payload(100);
        wait_writes(100, 64);
        check("mid_writes", wr_cnt - wr_base, 100);
        resetn = 1'b0;
        #1;
        check("mid_rst_write", mem_write, 0);
        check("mid_rst_refresh", mem_refresh, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_din", mem_din, 0);
        check("mid_rst_mapper", mapper, 0);
        check("mid_rst_units", {prg_units, chr_units}, 0);
        check("mid_rst_flags", {done, error}, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        resetn  = 1'b1;
        aborted = 1'b0;
        @(negedge clk);
        wr_base = wr_cnt;
        prg_bytes = 16384; tot_bytes = 16384;
        send_header(8'h1A, 8'h01, 8'h00, 8'h00, 8'h00);
        send_payload(1);
        wait_writes(1, 64);
        check("reload_writes", wr_cnt - wr_base, 1);
        check("reload_first_addr", first_addr, 22'h000000);
        check("reload_first_din", first_din, 8'h5A);
        check("reload_sequence", seq_err - seq_base, 0);
        do_reset();

        check("protocol", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
